// File: rtl/io_port_bridge_if.sv
// Signal bundle between the I/O bridge and its surroundings: the external ingress stream,
// the core-side read_in/write_out pins, the external egress stream and the status outputs.
// The slave modport is the bridge's view and the master modport is the environment's view.
interface io_port_bridge_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // External ingress stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  // Core side
  logic [WIDTH-1:0] core_read_data;
  logic             core_rd_en;
  logic [WIDTH-1:0] core_write_data;
  logic             core_wr_en;
  // External egress stream
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  // Status
  logic [CW-1:0]    rx_count;
  logic [CW-1:0]    tx_count;
  logic             rx_underflow;
  logic             tx_overflow;
  logic             err_clr;

  modport slave (
    input  in_valid, in_data, core_rd_en, core_write_data, core_wr_en, out_ready, err_clr,
    output in_ready, core_read_data, out_valid, out_data, rx_count, tx_count,
           rx_underflow, tx_overflow
  );

  modport master (
    output in_valid, in_data, core_rd_en, core_write_data, core_wr_en, out_ready, err_clr,
    input  in_ready, core_read_data, out_valid, out_data, rx_count, tx_count,
           rx_underflow, tx_overflow
  );
endinterface

// File: rtl/io_port_bridge.sv
// Buffered bridge between the core's read_in/write_out pins and external valid/ready streams.
// An RX FIFO holds incoming words and shows its head to the core; a TX FIFO collects core
// stores and drains them downstream. Fill levels and sticky error flags are reported.
module io_port_bridge #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input logic              clock,
  input logic              rst,
  io_port_bridge_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // RX FIFO state
  logic [WIDTH-1:0] rx_mem [DEPTH];
  logic [AW-1:0]    rx_wptr_q, rx_wptr_d;
  logic [AW-1:0]    rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]    rx_count_q, rx_count_d;
  logic             in_ready_q, in_ready_d;
  logic             rx_empty, rx_push, rx_pop;

  // TX FIFO state
  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wptr_q, tx_wptr_d;
  logic [AW-1:0]    tx_rptr_q, tx_rptr_d;
  logic [CW-1:0]    tx_count_q, tx_count_d;
  logic             tx_empty, tx_full, tx_push, tx_pop;

  // Sticky error flags
  logic             rx_uf_q, rx_uf_d;
  logic             tx_of_q, tx_of_d;

  // RX next state; in_ready is derived from the next count so it never depends on core_rd_en
  // combinationally.
  always_comb begin
    rx_empty   = (rx_count_q == '0);
    rx_push    = bus.in_valid & in_ready_q;
    rx_pop     = bus.core_rd_en & ~rx_empty;
    rx_wptr_d  = rx_push ? rx_wptr_q + AW'(1) : rx_wptr_q;
    rx_rptr_d  = rx_pop ? rx_rptr_q + AW'(1) : rx_rptr_q;
    rx_count_d = rx_count_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + CW'(1);
      2'b01:   rx_count_d = rx_count_q - CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
    in_ready_d = (rx_count_d != FullCount);
  end

  // TX next state; a push into a full FIFO is still accepted when the head leaves this cycle.
  always_comb begin
    tx_empty   = (tx_count_q == '0);
    tx_full    = (tx_count_q == FullCount);
    tx_pop     = bus.out_ready & ~tx_empty;
    tx_push    = bus.core_wr_en & (~tx_full | tx_pop);
    tx_wptr_d  = tx_push ? tx_wptr_q + AW'(1) : tx_wptr_q;
    tx_rptr_d  = tx_pop ? tx_rptr_q + AW'(1) : tx_rptr_q;
    tx_count_d = tx_count_q;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CW'(1);
      2'b01:   tx_count_d = tx_count_q - CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  // Sticky flags: a new error in the same cycle as err_clr keeps the flag set.
  always_comb begin
    rx_uf_d = (rx_uf_q & ~bus.err_clr) | (bus.core_rd_en & rx_empty);
    tx_of_d = (tx_of_q & ~bus.err_clr) | (bus.core_wr_en & ~tx_push);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_count_q <= '0;
      in_ready_q <= 1'b0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
      rx_uf_q    <= 1'b0;
      tx_of_q    <= 1'b0;
    end else begin
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_count_q <= rx_count_d;
      in_ready_q <= in_ready_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_count_q <= tx_count_d;
      rx_uf_q    <= rx_uf_d;
      tx_of_q    <= tx_of_d;
    end
  end

  // Storage arrays; contents are not reset since the counts gate every read.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wptr_q] <= bus.in_data;
    if (tx_push) tx_mem[tx_wptr_q] <= bus.core_write_data;
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.core_read_data = rx_empty ? '0 : rx_mem[rx_rptr_q];
  assign bus.out_valid      = ~tx_empty;
  assign bus.out_data       = tx_empty ? '0 : tx_mem[tx_rptr_q];
  assign bus.rx_count       = rx_count_q;
  assign bus.tx_count       = tx_count_q;
  assign bus.rx_underflow   = rx_uf_q;
  assign bus.tx_overflow    = tx_of_q;
endmodule

// File: tb/tb_io_port_bridge.sv
// Self-checking bench for io_port_bridge: a queue-based reference model is checked against
// the DUT every cycle, a small table of vectors carries hand-derived expectations, and
// directed sequences cover fill/overflow/reset corners.
module tb_io_port_bridge;
  localparam int unsigned W = 16;
  localparam int unsigned D = 8;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  io_port_bridge_if #(.WIDTH(W), .DEPTH(D)) bus ();

  io_port_bridge #(.WIDTH(W), .DEPTH(D)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] rxq[$];
  logic [W-1:0] txq[$];
  logic         m_in_ready;
  logic         m_uf;
  logic         m_of;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         rd;
    logic         wr;
    logic [W-1:0] wd;
    logic         ordy;
    logic         ec;
    int           e_rx;
    logic [W-1:0] e_crd;
    int           e_tx;
    logic [W-1:0] e_od;
    logic         e_uf;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [W-1:0] e_crd;
    logic [W-1:0] e_od;
    e_crd = (rxq.size() != 0) ? rxq[0] : '0;
    e_od  = (txq.size() != 0) ? txq[0] : '0;
    chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready));
    chk("rx_count", 32'(bus.rx_count), rxq.size());
    chk("tx_count", 32'(bus.tx_count), txq.size());
    chk("core_read_data", 32'(bus.core_read_data), 32'(e_crd));
    chk("out_valid", 32'(bus.out_valid), 32'(txq.size() != 0));
    chk("out_data", 32'(bus.out_data), 32'(e_od));
    chk("rx_underflow", 32'(bus.rx_underflow), 32'(m_uf));
    chk("tx_overflow", 32'(bus.tx_overflow), 32'(m_of));
  endtask

  // Called at posedge+1: drive inputs, check pre-edge outputs, advance the model, take the edge.
  task automatic cycle(input logic iv, input logic [W-1:0] id, input logic rd, input logic wr,
                       input logic [W-1:0] wd, input logic ordy, input logic ec);
    logic new_uf, new_of, tx_pop, rx_acc;
    bus.in_valid        = iv;
    bus.in_data         = id;
    bus.core_rd_en      = rd;
    bus.core_wr_en      = wr;
    bus.core_write_data = wd;
    bus.out_ready       = ordy;
    bus.err_clr         = ec;
    #3;
    check_model();
    new_uf = rd && (rxq.size() == 0);
    rx_acc = iv && m_in_ready;
    tx_pop = ordy && (txq.size() != 0);
    new_of = wr && (txq.size() == D) && !tx_pop;
    if (rd && rxq.size() != 0) void'(rxq.pop_front());
    if (rx_acc) rxq.push_back(id);
    if (tx_pop) void'(txq.pop_front());
    if (wr && !new_of) txq.push_back(wd);
    m_uf = (m_uf && !ec) || new_uf;
    m_of = (m_of && !ec) || new_of;
    m_in_ready = (rxq.size() != D);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    m_in_ready = 1'b0;
    m_uf = 1'b0;
    m_of = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // iv id rd wr wd ordy ec | rx crd tx od uf (expected after the edge)
    vt[0] = '{1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 16'h1111, 0, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 16'h2222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2, 16'h1111, 0, 16'h0000, 1'b0};
    vt[2] = '{1'b1, 16'h3333, 1'b0, 1'b1, 16'hA0A0, 1'b0, 1'b0, 3, 16'h1111, 1, 16'hA0A0, 1'b0};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 2, 16'h2222, 1, 16'hA0A0, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hB0B0, 1'b1, 1'b0, 1, 16'h3333, 1, 16'hB0B0, 1'b0};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 0, 16'h0000, 1'b0};
    vt[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0000, 1'b1};
    vt[7] = '{1'b1, 16'h4444, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 16'h4444, 0, 16'h0000, 1'b1};
    vt[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 16'h4444, 0, 16'h0000, 1'b0};
    vt[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 0, 16'h0000, 0, 16'h0000, 1'b0};

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.core_rd_en = 1'b0; bus.core_wr_en = 1'b0;
    bus.core_write_data = '0; bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_model();
    rst = 1'b0;
    idle();  // first edge after release raises in_ready
    chk("in_ready after release", 32'(bus.in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      cycle(vt[i].iv, vt[i].id, vt[i].rd, vt[i].wr, vt[i].wd, vt[i].ordy, vt[i].ec);
      chk($sformatf("vec%0d rx_count", i), 32'(bus.rx_count), vt[i].e_rx);
      chk($sformatf("vec%0d core_read_data", i), 32'(bus.core_read_data), 32'(vt[i].e_crd));
      chk($sformatf("vec%0d tx_count", i), 32'(bus.tx_count), vt[i].e_tx);
      chk($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vt[i].e_od));
      chk($sformatf("vec%0d rx_underflow", i), 32'(bus.rx_underflow), 32'(vt[i].e_uf));
    end

    // RX fill: in_valid held for DEPTH+1 words; the 9th waits for a pop.
    for (int i = 0; i < 9; i++) cycle(1'b1, W'(16'h5000 + i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rx full in_ready", 32'(bus.in_ready), 32'd0);
    chk("rx full count", 32'(bus.rx_count), 32'd8);
    cycle(1'b1, 16'h5008, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rx after pop count", 32'(bus.rx_count), 32'd7);
    chk("rx after pop in_ready", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, 16'h5008, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("rx 9th word accepted", 32'(bus.rx_count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    chk("rx drained", 32'(bus.rx_count), 32'd0);

    // TX overflow: 9 stores with the sink stalled.
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0, 1'b1, W'(16'h6000 + i), 1'b0, 1'b0);
    chk("tx full count", 32'(bus.tx_count), 32'd8);
    chk("tx_overflow set", 32'(bus.tx_overflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("tx_overflow cleared", 32'(bus.tx_overflow), 32'd0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("tx drained", 32'(bus.tx_count), 32'd0);

    // TX full with simultaneous push and pop; then a stalled sink must hold the head steady.
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b0, 1'b1, W'(16'h7000 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1, 16'h7ABC, 1'b1, 1'b0);
    chk("tx push+pop full count", 32'(bus.tx_count), 32'd8);
    chk("tx push+pop no overflow", 32'(bus.tx_overflow), 32'd0);
    chk("tx head after pop", 32'(bus.out_data), 32'h7001);
    for (int i = 0; i < 3; i++) idle();
    chk("tx head stable", 32'(bus.out_data), 32'h7001);
    for (int i = 0; i < 7; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("tx tail word", 32'(bus.out_data), 32'h7ABC);
    cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset mid-transfer with 4 words in each FIFO.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, W'(16'h8000 + i), 1'b0, 1'b1, W'(16'h9000 + i), 1'b0, 1'b0);
    chk("pre-reset rx_count", 32'(bus.rx_count), 32'd4);
    chk("pre-reset tx_count", 32'(bus.tx_count), 32'd4);
    bus.in_valid = 1'b1; bus.core_wr_en = 1'b0; bus.out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("reset rx_count", 32'(bus.rx_count), 32'd0);
    chk("reset tx_count", 32'(bus.tx_count), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset core_read_data", 32'(bus.core_read_data), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    rst = 1'b0;
    idle();
    idle();
    cycle(1'b1, 16'hCAFE, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("post-reset rx head", 32'(bus.core_read_data), 32'hCAFE);
    chk("post-reset tx head", 32'(bus.out_data), 32'hBEEF);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
